// File: rtl/gtech_nibble_deser.sv
// rtl/gtech_nibble_deser.sv - serial bit stream to 4-bit nibble deserializer with output FIFO
module gtech_nibble_deser #(
    parameter int MSB_FIRST = 1,
    parameter int DEPTH     = 2
) (
    input  logic       CP,
    input  logic       CD,
    input  logic       SI,
    input  logic       SI_VLD,
    input  logic       SI_SOF,
    output logic       SI_RDY,
    output logic [3:0] D_OUT,
    output logic       D_VLD,
    input  logic       D_RDY,
    output logic       FRM_ERR,
    input  logic       ERR_CLR
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      bit_cnt_q, bit_cnt_d;
    logic [3:0]      shift_q, shift_d;
    logic [3:0]      mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic            frm_err_q, frm_err_d;

    logic            acc;
    logic            pop;
    logic            push;
    logic [3:0]      shift_next;
    logic [3:0]      shift_first;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready looks only at registered state so the upstream never sees a D_RDY path.
    assign SI_RDY  = (bit_cnt_q != 2'd3) || (fifo_cnt_q < CW'(DEPTH));
    assign D_VLD   = (fifo_cnt_q != '0);
    assign D_OUT   = D_VLD ? mem_q[rd_ptr_q] : 4'h0;
    assign FRM_ERR = frm_err_q;
    assign acc     = SI_VLD && SI_RDY;
    assign pop     = D_VLD && D_RDY;

    always_comb begin
        if (MSB_FIRST != 0) begin
            shift_next  = {shift_q[2:0], SI};
            shift_first = {3'b000, SI};
        end else begin
            shift_next  = {SI, shift_q[3:1]};
            shift_first = {SI, 3'b000};
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frm_err_d = ERR_CLR ? 1'b0 : frm_err_q;
        if (acc) begin
            if (SI_SOF) begin
                // A new frame restarts assembly; any partial bits are dropped.
                if ((state_q == ACTIVE) && (bit_cnt_q != 2'd0)) begin
                    frm_err_d = 1'b1;
                end
                state_d   = ACTIVE;
                bit_cnt_d = 2'd1;
                shift_d   = shift_first;
            end else if (state_q == ACTIVE) begin
                bit_cnt_d = bit_cnt_q + 2'd1;
                shift_d   = shift_next;
                if (bit_cnt_q == 2'd3) begin
                    push    = 1'b1;
                    shift_d = 4'h0;
                end
            end
        end
    end

    always_comb begin
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            state_q    <= SYNC;
            bit_cnt_q  <= 2'd0;
            shift_q    <= 4'h0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            frm_err_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 4'h0;
            end
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            frm_err_q  <= frm_err_d;
            if (push) begin
                mem_q[wr_ptr_q] <= shift_next;
            end
        end
    end

endmodule

// File: tb/tb_gtech_nibble_deser.sv
// tb/tb_gtech_nibble_deser.sv - testbench for gtech_nibble_deser (MSB-first and LSB-first instances)
module tb_gtech_nibble_deser;

    localparam int DEPTH = 2;

    logic       cp, cd, si, vld, sof, drdy, clr;
    logic       a_rdy, a_vld, a_err, b_rdy, b_vld, b_err;
    logic [3:0] a_out, b_out;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic       mb[$];
    logic [3:0] mq[$];
    logic       m_frame;
    logic       m_err;
    logic [3:0] dut_q[$];

    typedef struct {
        logic       si, vld, sof, rdy, clr;
        logic       e_vld;
        logic [3:0] e_out_a, e_out_b;
        logic       e_rdy, e_err;
    } vec_t;
    vec_t tbl[12];

    gtech_nibble_deser #(.MSB_FIRST(1), .DEPTH(DEPTH)) u_a (
        .CP(cp), .CD(cd), .SI(si), .SI_VLD(vld), .SI_SOF(sof), .SI_RDY(a_rdy),
        .D_OUT(a_out), .D_VLD(a_vld), .D_RDY(drdy), .FRM_ERR(a_err), .ERR_CLR(clr)
    );

    gtech_nibble_deser #(.MSB_FIRST(0), .DEPTH(DEPTH)) u_b (
        .CP(cp), .CD(cd), .SI(si), .SI_VLD(vld), .SI_SOF(sof), .SI_RDY(b_rdy),
        .D_OUT(b_out), .D_VLD(b_vld), .D_RDY(drdy), .FRM_ERR(b_err), .ERR_CLR(clr)
    );

    initial begin
        cp = 1'b0;
        forever #5 cp = ~cp;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    function automatic logic m_rdy();
        return !((mb.size() == 3) && (mq.size() == DEPTH));
    endfunction

    task automatic m_reset();
        mb.delete();
        mq.delete();
        m_frame = 1'b0;
        m_err   = 1'b0;
    endtask

    // Reference: a frame is a list of bits since the last SOF; four bits make a nibble.
    task automatic m_step();
        logic       acc, pop, set, do_push;
        logic [3:0] nib;
        acc = vld && m_rdy();
        pop = (mq.size() > 0) && drdy;
        set = 1'b0;
        do_push = 1'b0;
        nib = 4'h0;
        if (acc) begin
            if (sof) begin
                if (m_frame && mb.size() != 0) set = 1'b1;
                mb.delete();
                mb.push_back(si);
                m_frame = 1'b1;
            end else if (m_frame) begin
                mb.push_back(si);
                if (mb.size() == 4) begin
                    nib = {mb[0], mb[1], mb[2], mb[3]};
                    do_push = 1'b1;
                    mb.delete();
                end
            end
        end
        if (pop) void'(mq.pop_front());
        if (do_push) mq.push_back(nib);
        m_err = set ? 1'b1 : (clr ? 1'b0 : m_err);
    endtask

    task automatic cyc(input logic s, input logic v, input logic f, input logic r, input logic c);
        logic [3:0] exp_a;
        si = s; vld = v; sof = f; drdy = r; clr = c;
        #1;
        exp_a = (mq.size() > 0) ? mq[0] : 4'h0;
        chk("a_vld", a_vld, mq.size() > 0);
        chk("a_out", a_out, exp_a);
        chk("a_rdy", a_rdy, m_rdy());
        chk("a_err", a_err, m_err);
        chk("b_vld", b_vld, mq.size() > 0);
        chk("b_out", b_out, rev4(exp_a));
        chk("b_rdy", b_rdy, m_rdy());
        chk("b_err", b_err, m_err);
        if (a_vld && drdy) dut_q.push_back(a_out);
        m_step();
        @(posedge cp);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n, input logic first_sof, input logic r);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 40) begin
            logic took;
            took = m_rdy();
            cyc(bits[n-1-i], 1'b1, first_sof && (i == 0), r, 1'b0);
            if (took) i++;
            guard++;
        end
        chk("send_done", i, n);
    endtask

    initial begin
        logic [3:0] exp_list [4];
        m_reset();
        cd = 1'b0; si = 0; vld = 0; sof = 0; drdy = 0; clr = 0;

        // T1: reset held with random inputs
        for (int k = 0; k < 4; k++) begin
            si = 1'($urandom); vld = 1'($urandom); sof = 1'($urandom);
            drdy = 1'($urandom); clr = 1'($urandom);
            @(posedge cp);
            #1;
            chk("rst_vld", a_vld, 1'b0);
            chk("rst_out", a_out, 4'h0);
            chk("rst_err", a_err, 1'b0);
            chk("rst_rdy", a_rdy, 1'b1);
            chk("rst_b_out", b_out, 4'h0);
        end
        si = 0; vld = 0; sof = 0; drdy = 0; clr = 0;
        cd = 1'b1;
        @(posedge cp);
        #1;
        cyc(0, 0, 0, 1, 0);

        // T2 + T4: hand-computed vectors, expectations after the clock edge
        tbl[0]  = '{1, 1, 1, 1, 0, 0, 4'h0, 4'h0, 1, 0};
        tbl[1]  = '{0, 1, 0, 1, 0, 0, 4'h0, 4'h0, 1, 0};
        tbl[2]  = '{1, 1, 0, 1, 0, 0, 4'h0, 4'h0, 1, 0};
        tbl[3]  = '{1, 1, 0, 1, 0, 1, 4'hB, 4'hD, 1, 0};
        tbl[4]  = '{0, 0, 0, 1, 0, 0, 4'h0, 4'h0, 1, 0};
        tbl[5]  = '{1, 1, 1, 1, 0, 0, 4'h0, 4'h0, 1, 0};
        tbl[6]  = '{0, 1, 0, 1, 0, 0, 4'h0, 4'h0, 1, 0};
        tbl[7]  = '{1, 1, 1, 1, 0, 0, 4'h0, 4'h0, 1, 1};
        tbl[8]  = '{0, 1, 0, 1, 0, 0, 4'h0, 4'h0, 1, 1};
        tbl[9]  = '{0, 1, 0, 1, 0, 0, 4'h0, 4'h0, 1, 1};
        tbl[10] = '{1, 1, 0, 1, 0, 1, 4'h9, 4'h9, 1, 1};
        tbl[11] = '{0, 0, 0, 1, 1, 0, 4'h0, 4'h0, 1, 0};
        for (int k = 0; k < 12; k++) begin
            cyc(tbl[k].si, tbl[k].vld, tbl[k].sof, tbl[k].rdy, tbl[k].clr);
            chk("tbl_vld", a_vld, tbl[k].e_vld);
            chk("tbl_out_a", a_out, tbl[k].e_out_a);
            chk("tbl_out_b", b_out, tbl[k].e_out_b);
            chk("tbl_rdy", a_rdy, tbl[k].e_rdy);
            chk("tbl_err", a_err, tbl[k].e_err);
        end

        // T3: backpressure, then drain in order
        dut_q.delete();
        send_bits(16'hA5, 8, 1'b1, 1'b0);
        send_bits(16'b110, 3, 1'b0, 1'b0);
        chk("bp_rdy", a_rdy, 1'b0);
        chk("bp_hold", a_out, 4'hA);
        cyc(0, 1, 0, 0, 0);
        chk("bp_stall_rdy", a_rdy, 1'b0);
        chk("bp_stall_out", a_out, 4'hA);
        send_bits(16'b00011, 5, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) cyc(0, 0, 0, 1, 0);
        exp_list = '{4'hA, 4'h5, 4'hC, 4'h3};
        chk("bp_count", dut_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < dut_q.size()) chk("bp_order", dut_q[k], exp_list[k]);
        end

        // T5: push and pop in the same cycle with one entry queued
        send_bits(16'b1110, 4, 1'b1, 1'b0);
        send_bits(16'b011, 3, 1'b0, 1'b0);
        cyc(1, 1, 0, 1, 0);
        chk("sim_vld", a_vld, 1'b1);
        chk("sim_out", a_out, 4'h7);
        cyc(0, 0, 0, 0, 0);
        chk("sim_hold", a_out, 4'h7);
        cyc(0, 0, 0, 1, 0);
        chk("sim_empty", a_vld, 1'b0);

        // T6: asynchronous reset mid-nibble with one entry queued
        send_bits(16'b1000, 4, 1'b1, 1'b0);
        send_bits(16'b11, 2, 1'b0, 1'b0);
        chk("pre6_vld", a_vld, 1'b1);
        cd = 1'b0;
        #1;
        chk("r6_vld", a_vld, 1'b0);
        chk("r6_out", a_out, 4'h0);
        chk("r6_rdy", a_rdy, 1'b1);
        m_reset();
        cd = 1'b1;
        @(posedge cp);
        #1;
        send_bits(16'b111101, 6, 1'b0, 1'b1);
        cyc(0, 0, 0, 1, 0);
        chk("r6_ignored", a_vld, 1'b0);

        // Randomized traffic against the reference model
        for (int k = 0; k < 2000; k++) begin
            cyc(1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
